// File: rtl/pwm_multich.sv
// Multi-channel PWM: shared prescaler/period counter, double-buffered duties reloaded at period boundaries.
// Optional PWM_CENTER_ALIGN_EN selects an up/down (center-aligned) counter; default is edge-aligned.
module pwm_multich #(
  parameter int  WIDTH    = 8,
  parameter int  CHANNELS = 4,
  parameter int  PRESC_W  = 16,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [PRESC_W-1:0]  prescale,
  input  logic [WIDTH-1:0]    period,
  input  logic                duty_wr,
  input  logic [CH_W-1:0]     duty_ch,
  input  logic [WIDTH-1:0]    duty_data,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_tick,
  output logic [CHANNELS-1:0] pending
);

  logic [PRESC_W-1:0]             presc_q, presc_d;
  logic [WIDTH-1:0]               cnt_q, cnt_d;
  logic [WIDTH-1:0]               period_q, period_d;
  logic [CHANNELS-1:0][WIDTH-1:0] shadow_q, shadow_d;
  logic [CHANNELS-1:0][WIDTH-1:0] active_q, active_d;
  logic [CHANNELS-1:0]            pending_q, pending_d;
  logic [CHANNELS-1:0]            pwm_q, pwm_d;
  logic                           tick_q, tick_d;
  logic                           tick;
  logic                           boundary;
`ifdef PWM_CENTER_ALIGN_EN
  logic                           dir_q, dir_d;
`endif

  always_comb begin
    tick    = enable && (presc_q == prescale);
    presc_d = '0;
    if (enable && !tick) presc_d = presc_q + 1'b1;
  end

`ifdef PWM_CENTER_ALIGN_EN
  // Up 0..period_q, down period_q-1..1; the step back to 0 is the boundary.
  always_comb begin
    boundary = 1'b0;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    if (!enable) begin
      cnt_d = '0;
      dir_d = 1'b0;
    end else if (tick) begin
      if (!dir_q && (cnt_q != period_q)) begin
        cnt_d = cnt_q + 1'b1;
      end else if (!dir_q && (period_q > WIDTH'(1))) begin
        cnt_d = cnt_q - 1'b1;
        dir_d = 1'b1;
      end else if (dir_q && (cnt_q > WIDTH'(1))) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        boundary = 1'b1;
        cnt_d    = '0;
        dir_d    = 1'b0;
      end
    end
  end
`else
  always_comb begin
    boundary = tick && (cnt_q == period_q);
    cnt_d    = cnt_q;
    if (!enable || boundary) cnt_d = '0;
    else if (tick)           cnt_d = cnt_q + 1'b1;
  end
`endif

  always_comb begin
    period_d  = (!enable || boundary) ? period : period_q;
    shadow_d  = shadow_q;
    pending_d = (!enable || boundary) ? '0 : pending_q;
    // Out-of-range channel indices match no channel and are dropped.
    for (int i = 0; i < CHANNELS; i++) begin
      if (duty_wr && (duty_ch == CH_W'(i))) begin
        shadow_d[i] = duty_data;
        if (enable) pending_d[i] = 1'b1;
      end
    end
    // A write coinciding with a boundary reaches shadow only; active takes the old shadow.
    active_d = !enable ? shadow_d : (boundary ? shadow_q : active_q);
    for (int i = 0; i < CHANNELS; i++) begin
      pwm_d[i] = enable && (cnt_q < active_q[i]);
    end
    tick_d = boundary;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q   <= '0;
      cnt_q     <= '0;
      period_q  <= '0;
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= '0;
      pwm_q     <= '0;
      tick_q    <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      pwm_q     <= pwm_d;
      tick_q    <= tick_d;
    end
  end

`ifdef PWM_CENTER_ALIGN_EN
  always_ff @(posedge clk) begin
    if (reset) dir_q <= 1'b0;
    else       dir_q <= dir_d;
  end
`endif

  assign pwm_out     = pwm_q;
  assign period_tick = tick_q;
  assign pending     = pending_q;

endmodule

// File: tb/tb_pwm_multich.sv
// Directed bench for pwm_multich (edge-aligned build), five channels so index 7 is out of range.
module tb_pwm_multich;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [15:0] prescale;
  logic [7:0]  period;
  logic        duty_wr;
  logic [2:0]  duty_ch;
  logic [7:0]  duty_data;
  logic [4:0]  pwm_out;
  logic        period_tick;
  logic [4:0]  pending;

  int          n_checks;
  int          n_fail;
  int          cyc_len;
  int          hi_cnt [5];
  logic [4:0]  pend_mid;
  logic [4:0]  pend_end;

  pwm_multich #(.WIDTH(8), .CHANNELS(5), .PRESC_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .prescale    (prescale),
    .period      (period),
    .duty_wr     (duty_wr),
    .duty_ch     (duty_ch),
    .duty_data   (duty_data),
    .pwm_out     (pwm_out),
    .period_tick (period_tick),
    .pending     (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task step();
    @(posedge clk);
    #1;
  endtask

  task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task write_duty(input logic [2:0] ch, input logic [7:0] dat);
    duty_wr   = 1'b1;
    duty_ch   = ch;
    duty_data = dat;
    step();
    duty_wr   = 1'b0;
  endtask

  task wait_tick(input string tag);
    int n;
    n = 0;
    while (period_tick !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    check(tag, {31'd0, period_tick}, 32'd1);
  endtask

  // Runs from one period_tick sample to the next, counting high clocks per channel.
  // Optionally issues one write at sample wr_at of the cycle.
  task measure(input int wr_at, input logic [2:0] wch, input logic [7:0] wdat);
    bit done;
    done     = 1'b0;
    cyc_len  = 0;
    pend_mid = '0;
    for (int c = 0; c < 5; c++) hi_cnt[c] = 0;
    while (!done) begin
      step();
      cyc_len++;
      duty_wr = 1'b0;
      for (int c = 0; c < 5; c++) hi_cnt[c] += pwm_out[c] ? 1 : 0;
      if (cyc_len == wr_at + 1) pend_mid = pending;
      if (cyc_len == wr_at) begin
        duty_wr   = 1'b1;
        duty_ch   = wch;
        duty_data = wdat;
      end
      if (period_tick === 1'b1) begin
        done = 1'b1;
      end else if (cyc_len >= 100) begin
        check("measure_timeout", 32'd0, 32'd1);
        done = 1'b1;
      end
    end
    pend_end = pending;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    enable    = 1'b0;
    prescale  = 16'd0;
    period    = 8'd9;
    duty_wr   = 1'b0;
    duty_ch   = 3'd0;
    duty_data = 8'd0;
    repeat (3) step();
    check("rst_pwm", {27'd0, pwm_out}, 32'd0);
    check("rst_tick", {31'd0, period_tick}, 32'd0);
    check("rst_pending", {27'd0, pending}, 32'd0);

    // Edge-aligned, prescale 0, period 9; duties loaded while disabled.
    reset = 1'b0;
    step();
    write_duty(3'd0, 8'd3);
    write_duty(3'd2, 8'd5);
    step();
    check("dis_pending", {27'd0, pending}, 32'd0);
    check("dis_pwm", {27'd0, pwm_out}, 32'd0);
    enable = 1'b1;
    wait_tick("first_tick");
    measure(-1, 3'd0, 8'd0);
    check("c1_len", cyc_len, 32'd10);
    check("c1_ch0_hi", hi_cnt[0], 32'd3);
    check("c1_ch2_hi", hi_cnt[2], 32'd5);
    check("c1_ch3_hi", hi_cnt[3], 32'd0);
    measure(-1, 3'd0, 8'd0);
    check("c2_len", cyc_len, 32'd10);
    check("c2_ch0_hi", hi_cnt[0], 32'd3);

    // Mid-cycle write waits for the boundary.
    measure(4, 3'd2, 8'd8);
    check("mid_ch2_hi_old", hi_cnt[2], 32'd5);
    check("mid_pend_set", {31'd0, pend_mid[2]}, 32'd1);
    check("mid_pend_clr", {31'd0, pend_end[2]}, 32'd0);
    measure(-1, 3'd0, 8'd0);
    check("mid_ch2_hi_new", hi_cnt[2], 32'd8);

    // Write landing on the boundary clock.
    measure(9, 3'd0, 8'd6);
    check("bnd_ch0_hi", hi_cnt[0], 32'd3);
    check("bnd_pend_kept", {31'd0, pend_end[0]}, 32'd1);
    measure(-1, 3'd0, 8'd0);
    check("bnd_ch0_old", hi_cnt[0], 32'd3);
    check("bnd_pend_clr", {31'd0, pend_end[0]}, 32'd0);
    measure(-1, 3'd0, 8'd0);
    check("bnd_ch0_new", hi_cnt[0], 32'd6);

    // Duty extremes and an out-of-range channel index.
    measure(2, 3'd3, 8'd10);
    check("d0_ch3_low", hi_cnt[3], 32'd0);
    measure(2, 3'd3, 8'd255);
    check("d10_ch3_high", hi_cnt[3], 32'd10);
    measure(3, 3'd7, 8'd1);
    check("d255_ch3_high", hi_cnt[3], 32'd10);
    check("oor_pending", {27'd0, pend_mid}, 32'd0);
    measure(-1, 3'd0, 8'd0);
    check("oor_ch0_hi", hi_cnt[0], 32'd6);
    check("oor_ch1_hi", hi_cnt[1], 32'd0);
    check("oor_ch4_hi", hi_cnt[4], 32'd0);
    check("oor_len", cyc_len, 32'd10);

    // Prescaled operation: prescale 3, period 4.
    enable = 1'b0;
    step();
    step();
    prescale = 16'd3;
    period   = 8'd4;
    write_duty(3'd1, 8'd2);
    step();
    check("psc_dis_pending", {27'd0, pending}, 32'd0);
    enable = 1'b1;
    wait_tick("psc_first_tick");
    measure(-1, 3'd0, 8'd0);
    check("psc_len", cyc_len, 32'd20);
    check("psc_ch1_hi", hi_cnt[1], 32'd8);
    check("psc_ch0_over", hi_cnt[0], 32'd20);
    check("psc_ch3_over", hi_cnt[3], 32'd20);

    // Reset in the middle of a pulse with a write pending.
    write_duty(3'd2, 8'd1);
    check("pre_rst_pwm1", {31'd0, pwm_out[1]}, 32'd1);
    check("pre_rst_pend2", {31'd0, pending[2]}, 32'd1);
    reset = 1'b1;
    step();
    check("mid_rst_pwm", {27'd0, pwm_out}, 32'd0);
    check("mid_rst_pending", {27'd0, pending}, 32'd0);
    check("mid_rst_tick", {31'd0, period_tick}, 32'd0);
    reset = 1'b0;
    wait_tick("post_rst_tick");
    measure(-1, 3'd0, 8'd0);
    check("post_rst_len", cyc_len, 32'd20);
    check("post_rst_ch0", hi_cnt[0], 32'd0);
    check("post_rst_ch1", hi_cnt[1], 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
